// File: rtl/mem_access_unit.sv
// mem_access_unit
// Sits between the multicycle controller/datapath and the unified
// instruction/data memory. It turns the controller's MemRead/MemWrite/IorD
// strobes into one registered request/acknowledge transaction with a
// variable-latency memory. While an access is in flight it stalls the
// controller, and it captures read data in the memory data register.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   MemRead    controller read strobe
//   MemWrite   controller write strobe
//   IorD       0 = address from pc, 1 = address from alu_out
//   pc         program counter
//   alu_out    ALU output register (data address)
//   wdata      store data (B register)
//   mem_req    registered request to memory
//   mem_we     1 = write, valid with mem_req
//   mem_addr   latched access address
//   mem_wdata  latched store data
//   mem_ack    memory completion, only looked at while a request is open
//   mem_rdata  read data, valid with mem_ack
//   mem_stall  controller holds its state while high
//   mdr        memory data register
//   align_err  sticky misalignment flag
//   bus_err    sticky timeout / illegal-request flag
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 16,
  parameter int CHECK_ALIGN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] mdr,
  output logic              align_err,
  output logic              bus_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    ERR
  } stateT;

  stateT             state;
  logic [CNT_W-1:0]  waitCnt;
  logic              req;
  logic [ADDR_W-1:0] selAddr;
  logic              misaligned;

  // Decode the controller's strobes into a request and the address it targets.
  // Alignment is only enforced when the CHECK_ALIGN parameter enables it.
  always_comb begin
    req        = MemRead | MemWrite;
    selAddr    = IorD ? alu_out : pc;
    misaligned = (CHECK_ALIGN != 0) && (selAddr[1:0] != 2'b00);
  end

  // The controller must freeze while a request is pending in IDLE, while the
  // memory is being waited on, and forever once an error has been flagged.
  // DONE is the one cycle where it is released to advance.
  always_comb begin
    mem_stall = ((state == IDLE) && req) || (state == REQ) || (state == ERR);
  end

  // Access sequencer. Illegal requests (both strobes, or a misaligned address)
  // go straight to the terminal error state without touching memory. A legal
  // request latches address/data and holds mem_req until the memory acks or
  // the wait counter expires; the counter value TIMEOUT-1 marks the last
  // allowed REQ cycle, so the bus error fires after exactly TIMEOUT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mdr       <= '0;
      waitCnt   <= '0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (MemRead && MemWrite) begin
              bus_err <= 1'b1;
              state   <= ERR;
            end else if (misaligned) begin
              align_err <= 1'b1;
              state     <= ERR;
            end else begin
              mem_addr  <= selAddr;
              mem_wdata <= wdata;
              mem_we    <= MemWrite;
              mem_req   <= 1'b1;
              waitCnt   <= '0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (!mem_we) begin
              mdr <= mem_rdata;
            end
            waitCnt <= '0;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
            bus_err <= 1'b1;
            mem_req <= 1'b0;
            waitCnt <= '0;
            state   <= ERR;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        ERR: begin
          mem_req <= 1'b0;
          state   <= ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Self-checking bench for mem_access_unit. A transaction-level reference
// model predicts, for each access, how long the controller is stalled, how
// long mem_req stays up, what gets latched onto the memory bus and what the
// memory data register must hold. Directed scenarios cover the fetch, store,
// misalignment, timeout, reset-mid-access and back-to-back cases; a random
// loop covers mixed reads/writes with random wait states.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic        IorD;
  logic [31:0] pc;
  logic [31:0] alu_out;
  logic [31:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic [31:0] mdr;
  logic        align_err;
  logic        bus_err;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mdrModel;

  mem_access_unit #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .TIMEOUT    (16),
    .CHECK_ALIGN(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IorD     (IorD),
    .pc       (pc),
    .alu_out  (alu_out),
    .wdata    (wdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .mem_stall(mem_stall),
    .mdr      (mdr),
    .align_err(align_err),
    .bus_err  (bus_err)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case the bench itself wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic iord,
                               input logic [31:0] p, input logic [31:0] a,
                               input logic [31:0] wd);
    MemRead  = rd;
    MemWrite = wr;
    IorD     = iord;
    pc       = p;
    alu_out  = a;
    wdata    = wd;
    #1;
  endtask

  task automatic resetDut();
    rst       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) stepClk();
    rst      = 1'b1;
    mdrModel = '0;
    #1;
  endtask

  // One complete legal access. The memory acks after `waits` wait cycles.
  // Expected: stall lasts waits+2 cycles, mem_req waits+1 cycles, and in the
  // DONE cycle the bus shows the latched access and mdr the model's value.
  task automatic runAccess(input logic isWrite, input logic iord,
                           input logic [31:0] p, input logic [31:0] a,
                           input logic [31:0] wd, input int waits,
                           input logic [31:0] rdataVal);
    int          stallCycles;
    int          reqCycles;
    logic        done;
    logic [31:0] expAddr;
    stallCycles = 0;
    reqCycles   = 0;
    done        = 1'b0;
    expAddr     = iord ? a : p;
    applyStimulus(!isWrite, isWrite, iord, p, a, wd);
    for (int c = 0; c < 100 && !done; c++) begin
      if (!mem_stall) begin
        done = 1'b1;
      end else begin
        stallCycles++;
        if (mem_req) begin
          reqCycles++;
          mem_ack   = (reqCycles == waits + 1);
          mem_rdata = mem_ack ? rdataVal : $urandom();
        end else begin
          mem_ack = 1'b0;
        end
        stepClk();
      end
    end
    mem_ack   = 1'b0;
    mem_rdata = '0;
    if (!isWrite) mdrModel = rdataVal;
    checkOutput("done_reached", done, 1'b1);
    checkOutput("stall_cycles", stallCycles, waits + 2);
    checkOutput("req_cycles", reqCycles, waits + 1);
    checkOutput("mem_addr", mem_addr, expAddr);
    checkOutput("mem_we", mem_we, isWrite);
    checkOutput("mem_wdata", mem_wdata, wd);
    checkOutput("mdr", mdr, mdrModel);
    checkOutput("req_in_done", mem_req, 1'b0);
    checkOutput("err_flags", {align_err, bus_err}, 2'b00);
    stepClk();
    applyStimulus(1'b0, 1'b0, iord, p, a, wd);
  endtask

  initial begin
    int reqCycles;
    int gap;

    // Reset state.
    resetDut();
    checkOutput("rst_req", mem_req, 1'b0);
    checkOutput("rst_we", mem_we, 1'b0);
    checkOutput("rst_addr", mem_addr, 32'h0);
    checkOutput("rst_wdata", mem_wdata, 32'h0);
    checkOutput("rst_mdr", mdr, 32'h0);
    checkOutput("rst_flags", {align_err, bus_err}, 2'b00);
    checkOutput("rst_stall", mem_stall, 1'b0);

    // Fetch with zero wait states.
    runAccess(1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 0, 32'h8C220004);

    // Store with three wait states: mdr must keep the fetched word.
    runAccess(1'b1, 1'b1, 32'h0, 32'h2004, 32'hDEADBEEF, 3, 32'h0);

    // Ack while idle is ignored.
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    stepClk();
    mem_ack   = 1'b0;
    checkOutput("idle_ack_mdr", mdr, mdrModel);
    checkOutput("idle_ack_req", mem_req, 1'b0);

    // Back-to-back reads.
    runAccess(1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 0, 32'hAAAA0001);
    runAccess(1'b0, 1'b0, 32'h104, 32'h0, 32'h0, 1, 32'hBBBB0002);

    // Random mix of reads and writes with random wait states and gaps.
    for (int t = 0; t < 40; t++) begin
      runAccess(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom() & ~32'h3, $urandom() & ~32'h3, $urandom(),
                $urandom_range(0, 5), $urandom());
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom();
        stepClk();
      end
      mem_ack = 1'b0;
    end

    // Reset in the second REQ cycle: outputs drop without a clock edge.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0);
    stepClk();
    stepClk();
    checkOutput("mid_req_high", mem_req, 1'b1);
    #2;
    rst     = 1'b0;
    MemRead = 1'b0;
    #1;
    mdrModel = '0;
    checkOutput("mid_rst_req", mem_req, 1'b0);
    checkOutput("mid_rst_stall", mem_stall, 1'b0);
    checkOutput("mid_rst_mdr", mdr, 32'h0);
    stepClk();
    rst = 1'b1;
    #1;
    runAccess(1'b0, 1'b1, 32'h0, 32'h400, 32'h0, 2, 32'hCAFEF00D);

    // Misaligned load goes to the error state without a memory request.
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 32'h2006, 32'h0);
    checkOutput("mis_stall_idle", mem_stall, 1'b1);
    stepClk();
    checkOutput("mis_align_err", align_err, 1'b1);
    checkOutput("mis_bus_err", bus_err, 1'b0);
    checkOutput("mis_req", mem_req, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h2006, 32'h0);
    repeat (3) stepClk();
    checkOutput("mis_stall_held", mem_stall, 1'b1);
    checkOutput("mis_req_held", mem_req, 1'b0);

    // Both strobes at once is an illegal request.
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0);
    stepClk();
    checkOutput("both_bus_err", bus_err, 1'b1);
    checkOutput("both_align_err", align_err, 1'b0);
    checkOutput("both_req", mem_req, 1'b0);

    // Timeout: no ack ever comes, bus error after 16 REQ cycles.
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0);
    stepClk();
    reqCycles = 0;
    for (int c = 0; c < 40; c++) begin
      if (!mem_req) break;
      reqCycles++;
      stepClk();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0);
    checkOutput("to_req_cycles", reqCycles, 16);
    checkOutput("to_bus_err", bus_err, 1'b1);
    checkOutput("to_stall", mem_stall, 1'b1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h55AA55AA;
    stepClk();
    mem_ack   = 1'b0;
    checkOutput("to_spur_mdr", mdr, mdrModel);
    checkOutput("to_spur_req", mem_req, 1'b0);
    checkOutput("to_spur_stall", mem_stall, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
